// File: rtl/axi_sram_responder.sv
// AXI4 slave over a DEPTH_WORDS x 32 dual-port SRAM with independent write and read FSMs.
// One outstanding transaction per direction; reads are write-first against a same-cycle W beat.
module axi_sram_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int ID_WIDTH    = 8
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast
);
    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT       = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [31:0]         r_mem [DEPTH_WORDS];
    logic                r_live;
    wstate_t             r_wstate, w_wstate_nxt;
    rstate_t             r_rstate, w_rstate_nxt;

    logic [ID_WIDTH-1:0] r_awid;
    logic [31:0]         r_waddr;
    logic [7:0]          r_awlen, r_wcnt;
    logic [2:0]          r_awsize;
    logic [1:0]          r_awburst, r_bresp;
    logic                r_wdec, r_wslv;

    logic [ID_WIDTH-1:0] r_arid;
    logic [31:0]         r_raddr, r_rdata;
    logic [7:0]          r_arlen, r_rcnt;
    logic [1:0]          r_arburst, r_rresp;
    logic                r_rslv, r_rlast;

    logic                w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic                w_wbeat_last, w_wbeat_dec, w_wbeat_slv, w_mem_we, w_rbeat_dec;
    logic [IDX_W-1:0]    w_widx, w_ridx;
    logic [31:0]         w_rword;

    // Handshake readies stay low until the first edge after reset release.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_live <= 1'b0;
        else            r_live <= 1'b1;
    end

    assign w_aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_w_hs       = s_axi_wvalid && s_axi_wready;
    assign w_wbeat_last = (r_wcnt == r_awlen);
    assign w_wbeat_dec  = ({1'b0, r_waddr} >= LIMIT);
    assign w_wbeat_slv  = (r_awsize != 3'd2) || (r_awburst == BURST_WRAP) || (s_axi_wlast != w_wbeat_last);
    assign w_mem_we     = w_w_hs && !(r_wdec || r_wslv) && !w_wbeat_dec && !w_wbeat_slv;
    assign w_widx       = r_waddr[IDX_W+1:2];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_wstate <= W_IDLE;
        else            r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_axi_awready = r_live;
                if (w_aw_hs) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (w_w_hs && w_wbeat_last) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_awid    <= '0;
            r_waddr   <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wcnt    <= '0;
            r_wdec    <= 1'b0;
            r_wslv    <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (w_aw_hs) begin
            r_awid    <= s_axi_awid;
            r_waddr   <= s_axi_awaddr;
            r_awlen   <= s_axi_awlen;
            r_awsize  <= s_axi_awsize;
            r_awburst <= s_axi_awburst;
            r_wcnt    <= '0;
            r_wdec    <= 1'b0;
            r_wslv    <= 1'b0;
        end else if (w_w_hs) begin
            r_wcnt <= r_wcnt + 8'd1;
            if (r_awburst != BURST_FIXED) r_waddr <= r_waddr + 32'd4;
            r_wdec <= r_wdec | w_wbeat_dec;
            r_wslv <= r_wslv | w_wbeat_slv;
            if (w_wbeat_last)
                r_bresp <= (r_wdec || w_wbeat_dec) ? RESP_DECERR :
                           (r_wslv || w_wbeat_slv) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign s_axi_bid   = r_awid;
    assign s_axi_bresp = r_bresp;

    always_ff @(posedge i_clock) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < 4; b++)
                if (s_axi_wstrb[b]) r_mem[w_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
    end

    assign w_ar_hs     = s_axi_arvalid && s_axi_arready;
    assign w_r_hs      = s_axi_rvalid && s_axi_rready;
    assign w_ridx      = r_raddr[IDX_W+1:2];
    assign w_rbeat_dec = ({1'b0, r_raddr} >= LIMIT);

    // A W beat landing on the fetched word in the same cycle is forwarded (write-first).
    always_comb begin
        w_rword = r_mem[w_ridx];
        if (w_mem_we && (w_widx == w_ridx)) begin
            for (int unsigned b = 0; b < 4; b++)
                if (s_axi_wstrb[b]) w_rword[8*b +: 8] = s_axi_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_rstate <= R_IDLE;
        else            r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_axi_arready = r_live;
                if (w_ar_hs) w_rstate_nxt = R_FETCH;
            end
            R_FETCH: w_rstate_nxt = R_DATA;
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) w_rstate_nxt = r_rlast ? R_IDLE : R_FETCH;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_arid    <= '0;
            r_raddr   <= '0;
            r_arlen   <= '0;
            r_arburst <= '0;
            r_rslv    <= 1'b0;
            r_rcnt    <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_arid    <= s_axi_arid;
                r_raddr   <= s_axi_araddr;
                r_arlen   <= s_axi_arlen;
                r_arburst <= s_axi_arburst;
                r_rslv    <= (s_axi_arsize != 3'd2) || (s_axi_arburst == BURST_WRAP);
                r_rcnt    <= '0;
            end
            if (r_rstate == R_FETCH) begin
                r_rlast <= (r_rcnt == r_arlen);
                if (w_rbeat_dec) begin
                    r_rresp <= RESP_DECERR;
                    r_rdata <= '0;
                end else if (r_rslv) begin
                    r_rresp <= RESP_SLVERR;
                    r_rdata <= '0;
                end else begin
                    r_rresp <= RESP_OKAY;
                    r_rdata <= w_rword;
                end
            end
            if (w_r_hs && !r_rlast) begin
                r_rcnt <= r_rcnt + 8'd1;
                if (r_arburst != BURST_FIXED) r_raddr <= r_raddr + 32'd4;
            end
        end
    end

    assign s_axi_rid   = r_arid;
    assign s_axi_rdata = r_rdata;
    assign s_axi_rresp = r_rresp;
    assign s_axi_rlast = r_rlast;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Self-checking bench for axi_sram_responder: directed table, hand-written corner sequences,
// and randomized bursts checked against a byte-level memory model.
module tb_axi_sram_responder;
    localparam int          DEPTH = 4096;
    localparam int          IDW   = 8;
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            awvalid = 1'b0, awready;
    logic [IDW-1:0]  awid = '0;
    logic [31:0]     awaddr = '0;
    logic [7:0]      awlen = '0;
    logic [2:0]      awsize = '0;
    logic [1:0]      awburst = '0;
    logic            wvalid = 1'b0, wready;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wlast = 1'b0;
    logic            bvalid, bready = 1'b0;
    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;
    logic            arvalid = 1'b0, arready;
    logic [IDW-1:0]  arid = '0;
    logic [31:0]     araddr = '0;
    logic [7:0]      arlen = '0;
    logic [2:0]      arsize = '0;
    logic [1:0]      arburst = '0;
    logic            rvalid, rready = 1'b0;
    logic [IDW-1:0]  rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;

    always #5 clk = ~clk;

    axi_sram_responder #(.DEPTH_WORDS(DEPTH), .ID_WIDTH(IDW)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast)
    );

    int n_vec = 0;
    int n_mis = 0;

    logic [31:0]    m_data  [DEPTH];
    logic [3:0]     m_known [DEPTH];
    logic [31:0]    g_wdata [256];
    logic [3:0]     g_wstrb [256];
    logic           g_wlast [256];
    logic [31:0]    g_rdata [256];
    logic [1:0]     g_rresp [256];
    logic           g_rlast [256];
    logic [IDW-1:0] g_rid   [256];
    int             g_rlat;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  wsize;
        logic [1:0]  wburst;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s: handshake did not occur within 50 cycles", name);
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            output logic [1:0] resp, output logic [IDW-1:0] rbid, output bit ok);
        int t;
        ok = 1'b0; resp = 2'bxx; rbid = 'x;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        t = 0;
        while (!awready && t < 50) begin tick(); t++; end
        if (!awready) begin awvalid = 1'b0; tmo("aw_handshake"); return; end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = g_wdata[i]; wstrb = g_wstrb[i]; wlast = g_wlast[i];
            t = 0;
            while (!wready && t < 50) begin tick(); t++; end
            if (!wready) begin wvalid = 1'b0; tmo("w_handshake"); return; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin tick(); t++; end
        if (!bvalid) begin bready = 1'b0; tmo("b_handshake"); return; end
        resp = bresp; rbid = bid;
        tick();
        bready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit ok);
        int t;
        ok = 1'b0;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        t = 0;
        while (!arready && t < 50) begin tick(); t++; end
        if (!arready) begin arvalid = 1'b0; tmo("ar_handshake"); return; end
        tick();
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            rready = 1'b1;
            t = 0;
            while (!rvalid && t < 50) begin tick(); t++; end
            if (!rvalid) begin rready = 1'b0; tmo("r_handshake"); return; end
            if (i == 0) g_rlat = t + 1;
            g_rdata[i] = rdata; g_rresp[i] = rresp; g_rlast[i] = rlast; g_rid[i] = rid;
            tick();
        end
        rready = 1'b0;
        ok = 1'b1;
    endtask

    // Reference: apply beats in order; the first erroring beat stops all further writes.
    function automatic logic [1:0] mdl_write(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        logic dec = 1'b0, slv = 1'b0, stop = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] a;
            logic        bd, bs;
            int          w;
            a  = addr + ((burst == 2'b00) ? 32'd0 : 32'(i) * 32'd4);
            bd = (a >= LIMIT);
            bs = (size != 3'd2) || (burst == 2'b10) || (g_wlast[i] != (i == int'(len)));
            dec |= bd;
            slv |= bs;
            if (bd || bs) stop = 1'b1;
            if (!stop) begin
                w = int'(a >> 2);
                for (int b = 0; b < 4; b++)
                    if (g_wstrb[i][b]) begin
                        m_data[w][8*b +: 8] = g_wdata[i][8*b +: 8];
                        m_known[w][b] = 1'b1;
                    end
            end
        end
        return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    task automatic chk_read(input string tag, input logic [IDW-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] a, ed, mask;
            logic [1:0]  er;
            int          w;
            a = addr + ((burst == 2'b00) ? 32'd0 : 32'(i) * 32'd4);
            mask = '1;
            if (a >= LIMIT) begin
                er = 2'b11; ed = '0;
            end else if (size != 3'd2 || burst == 2'b10) begin
                er = 2'b10; ed = '0;
            end else begin
                w = int'(a >> 2);
                er = 2'b00; ed = m_data[w];
                for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{m_known[w][b]}};
            end
            chk($sformatf("%s.rresp[%0d]", tag, i), 32'(g_rresp[i]), 32'(er));
            chk($sformatf("%s.rlast[%0d]", tag, i), 32'(g_rlast[i]), 32'(i == int'(len)));
            chk($sformatf("%s.rid[%0d]", tag, i), 32'(g_rid[i]), 32'(id));
            if (mask != '0)
                chk($sformatf("%s.rdata[%0d]", tag, i), g_rdata[i] & mask, ed & mask);
        end
    endtask

    task automatic single_beats(input int n, input logic [31:0] base_data);
        for (int i = 0; i < n; i++) begin
            g_wdata[i] = base_data + 32'(i); g_wstrb[i] = 4'hF; g_wlast[i] = (i == n - 1);
        end
    endtask

    initial begin
        logic [1:0]     resp;
        logic [IDW-1:0] rb;
        bit             ok, ok2;
        logic [31:0]    hold_data;

        for (int i = 0; i < DEPTH; i++) begin m_data[i] = '0; m_known[i] = '0; end

        tbl[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 2'b01, 2'b00, 32'hDEAD_BEEF, 2'b00};
        tbl[1] = '{32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3'd2, 2'b01, 2'b00, 32'hFFFF_FFFF, 2'b00};
        tbl[2] = '{32'h0000_0020, 32'h0000_ABCD, 4'h3, 3'd2, 2'b01, 2'b00, 32'hFFFF_ABCD, 2'b00};
        tbl[3] = '{32'h0000_0024, 32'hAABB_CCDD, 4'hF, 3'd2, 2'b00, 2'b00, 32'hAABB_CCDD, 2'b00};
        tbl[4] = '{32'h0000_0024, 32'h1111_1111, 4'hF, 3'd1, 2'b01, 2'b10, 32'hAABB_CCDD, 2'b00};
        tbl[5] = '{32'h0000_0024, 32'h2222_2222, 4'hF, 3'd2, 2'b10, 2'b10, 32'hAABB_CCDD, 2'b00};
        tbl[6] = '{32'h0000_3FFC, 32'h5A5A_5A5A, 4'hF, 3'd2, 2'b01, 2'b00, 32'h5A5A_5A5A, 2'b00};
        tbl[7] = '{32'h0000_3FFC, 32'hA500_0000, 4'h8, 3'd2, 2'b01, 2'b00, 32'hA55A_5A5A, 2'b00};
        tbl[8] = '{32'h0000_4000, 32'h0BAD_F00D, 4'hF, 3'd2, 2'b01, 2'b11, 32'h0000_0000, 2'b11};
        tbl[9] = '{32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 3'd2, 2'b01, 2'b11, 32'h0000_0000, 2'b11};

        // Reset state
        #2;
        chk("rst.awready", 32'(awready), 0);
        chk("rst.arready", 32'(arready), 0);
        chk("rst.wready",  32'(wready), 0);
        chk("rst.bvalid",  32'(bvalid), 0);
        chk("rst.rvalid",  32'(rvalid), 0);
        chk("rst.bid_bresp", {bid, bresp}, 0);
        chk("rst.rid_rresp_rlast", {rid, rresp, rlast}, 0);
        chk("rst.rdata", rdata, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rel.awready_before_edge", 32'(awready), 0);
        tick();
        chk("rel.awready", 32'(awready), 1);
        chk("rel.arready", 32'(arready), 1);

        // Single-beat table
        for (int i = 0; i < 10; i++) begin
            g_wdata[0] = tbl[i].wdata; g_wstrb[0] = tbl[i].wstrb; g_wlast[0] = 1'b1;
            do_write(8'(i + 1), tbl[i].addr, 8'd0, tbl[i].wsize, tbl[i].wburst, resp, rb, ok);
            void'(mdl_write(tbl[i].addr, 8'd0, tbl[i].wsize, tbl[i].wburst));
            if (ok) begin
                chk($sformatf("tbl%0d.bresp", i), 32'(resp), 32'(tbl[i].exp_bresp));
                chk($sformatf("tbl%0d.bid", i), 32'(rb), 32'(i + 1));
            end
            do_read(8'(i + 8'h40), tbl[i].addr, 8'd0, 3'd2, 2'b01, ok);
            if (ok) begin
                chk($sformatf("tbl%0d.rdata", i), g_rdata[0], tbl[i].exp_rdata);
                chk($sformatf("tbl%0d.rresp", i), 32'(g_rresp[0]), 32'(tbl[i].exp_rresp));
                chk($sformatf("tbl%0d.rlast", i), 32'(g_rlast[0]), 1);
                chk($sformatf("tbl%0d.rid", i), 32'(g_rid[0]), 32'(i + 8'h40));
                chk($sformatf("tbl%0d.latency", i), 32'(g_rlat), 2);
            end
        end

        // 4-beat INCR write/read
        single_beats(4, 32'd1);
        do_write(8'h33, 32'h100, 8'd3, 3'd2, 2'b01, resp, rb, ok);
        void'(mdl_write(32'h100, 8'd3, 3'd2, 2'b01));
        if (ok) begin chk("incr4.bresp", 32'(resp), 0); chk("incr4.bid", 32'(rb), 32'h33); end
        do_read(8'h5A, 32'h100, 8'd3, 3'd2, 2'b01, ok);
        if (ok) for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr4.rdata[%0d]", i), g_rdata[i], 32'(i + 1));
            chk($sformatf("incr4.rlast[%0d]", i), 32'(g_rlast[i]), 32'(i == 3));
            chk($sformatf("incr4.rid[%0d]", i), 32'(g_rid[i]), 32'h5A);
        end

        // Out-of-range burst must leave the aliased low words untouched
        g_wdata[0] = 32'h1357_9BDF; g_wdata[1] = 32'h2468_ACE0;
        g_wstrb[0] = 4'hF; g_wstrb[1] = 4'hF; g_wlast[0] = 1'b0; g_wlast[1] = 1'b1;
        do_write(8'h06, 32'h0, 8'd1, 3'd2, 2'b01, resp, rb, ok);
        void'(mdl_write(32'h0, 8'd1, 3'd2, 2'b01));
        g_wdata[0] = 32'hBAD0_0000; g_wdata[1] = 32'hBAD0_0001;
        do_write(8'h07, LIMIT, 8'd1, 3'd2, 2'b01, resp, rb, ok);
        void'(mdl_write(LIMIT, 8'd1, 3'd2, 2'b01));
        if (ok) chk("oor.bresp", 32'(resp), 32'h3);
        do_read(8'h08, LIMIT, 8'd0, 3'd2, 2'b01, ok);
        if (ok) begin chk("oor.rresp", 32'(g_rresp[0]), 32'h3); chk("oor.rdata", g_rdata[0], 0); end
        do_read(8'h09, 32'h0, 8'd1, 3'd2, 2'b01, ok);
        if (ok) begin
            chk("oor.word0", g_rdata[0], 32'h1357_9BDF);
            chk("oor.word1", g_rdata[1], 32'h2468_ACE0);
        end

        // Early wlast on beat 2 of 3
        single_beats(3, 32'hEEEE_0000);
        do_write(8'h0A, 32'h200, 8'd2, 3'd2, 2'b01, resp, rb, ok);
        void'(mdl_write(32'h200, 8'd2, 3'd2, 2'b01));
        g_wdata[0] = 32'hA; g_wdata[1] = 32'hB; g_wdata[2] = 32'hC;
        g_wlast[0] = 1'b0; g_wlast[1] = 1'b1; g_wlast[2] = 1'b1;
        do_write(8'h0B, 32'h200, 8'd2, 3'd2, 2'b01, resp, rb, ok);
        void'(mdl_write(32'h200, 8'd2, 3'd2, 2'b01));
        if (ok) chk("wlast.bresp", 32'(resp), 32'h2);
        do_read(8'h0C, 32'h200, 8'd2, 3'd2, 2'b01, ok);
        if (ok) begin
            chk("wlast.word0", g_rdata[0], 32'hA);
            chk("wlast.word1", g_rdata[1], 32'hEEEE_0001);
            chk("wlast.word2", g_rdata[2], 32'hEEEE_0002);
        end

        // Read fetch coinciding with a write beat to the same word
        single_beats(1, 32'h1111_1111);
        do_write(8'h0D, 32'h300, 8'd0, 3'd2, 2'b01, resp, rb, ok);
        void'(mdl_write(32'h300, 8'd0, 3'd2, 2'b01));
        g_wdata[0] = 32'h2222_2222;
        fork
            do_write(8'h0E, 32'h300, 8'd0, 3'd2, 2'b01, resp, rb, ok);
            do_read(8'h0F, 32'h300, 8'd0, 3'd2, 2'b01, ok2);
        join
        if (ok2) chk("wfirst.rdata", g_rdata[0], 32'h2222_2222);
        void'(mdl_write(32'h300, 8'd0, 3'd2, 2'b01));

        // Back-pressure mid-burst, then reset during the stalled beat
        single_beats(4, 32'h100);
        do_write(8'h10, 32'h400, 8'd3, 3'd2, 2'b01, resp, rb, ok);
        void'(mdl_write(32'h400, 8'd3, 3'd2, 2'b01));
        arvalid = 1'b1; arid = 8'h77; araddr = 32'h400; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        for (int t = 0; t < 50 && !rvalid; t++) tick();
        tick();
        rready = 1'b0;
        for (int t = 0; t < 50 && !rvalid; t++) tick();
        hold_data = 32'h101;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall.rvalid[%0d]", c), 32'(rvalid), 1);
            chk($sformatf("stall.fields[%0d]", c), {rid, 5'd0, rresp, rlast}, {8'h77, 5'd0, 2'b00, 1'b0});
            chk($sformatf("stall.rdata[%0d]", c), rdata, hold_data);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst.rvalid", 32'(rvalid), 0);
        chk("midrst.arready", 32'(arready), 0);
        chk("midrst.rdata", rdata, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst.arready_after", 32'(arready), 1);
        chk("midrst.awready_after", 32'(awready), 1);
        do_read(8'h78, 32'h400, 8'd0, 3'd2, 2'b01, ok);
        if (ok) chk("midrst.mem_kept", g_rdata[0], 32'h100);

        // Randomized bursts against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [IDW-1:0] id;
            logic [31:0]    addr;
            logic [7:0]     len;
            logic [2:0]     size;
            logic [1:0]     burst, exp;
            int             pick;
            id   = IDW'($urandom);
            len  = 8'($urandom_range(0, 7));
            pick = int'($urandom_range(0, 99));
            if (pick < 70)      addr = 32'h800 + 32'($urandom_range(0, 63)) * 4;
            else if (pick < 85) addr = LIMIT - 32'($urandom_range(1, 6)) * 4;
            else if (pick < 93) addr = 32'h800 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            else                addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
            pick = int'($urandom_range(0, 9));
            burst = (pick == 0) ? 2'b10 : ((pick < 3) ? 2'b00 : 2'b01);
            for (int i = 0; i <= int'(len); i++) begin
                g_wdata[i] = $urandom;
                g_wstrb[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                g_wlast[i] = (i == int'(len)) ^ ($urandom_range(0, 15) == 0);
            end
            do_write(id, addr, len, size, burst, resp, rb, ok);
            exp = mdl_write(addr, len, size, burst);
            if (ok) begin
                chk($sformatf("rnd%0d.bresp", n), 32'(resp), 32'(exp));
                chk($sformatf("rnd%0d.bid", n), 32'(rb), 32'(id));
            end
            if ($urandom_range(0, 3) == 0) size = 3'($urandom_range(1, 2));
            do_read(id ^ 8'hFF, addr, len, size, burst, ok);
            if (ok) chk_read($sformatf("rnd%0d", n), id ^ 8'hFF, addr, len, size, burst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
